// File: rtl/apb_mem_slave.sv
// APB4 memory-mapped slave with configurable width/depth, programmable wait states,
// byte strobes, read-only low words and PSLVERR responses with a saturating error count.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int RO_WORDS    = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [7:0]              err_count
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(NB);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [7:0]            errcnt_q, errcnt_d;

  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_write;
  logic [31:0]           rsp_idx;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  complete;
  logic                  mem_we;
  logic [31:0]           wr_idx;

  // The response is formed either straight from the setup-phase bus (zero waits)
  // or from the latched request at the end of the wait countdown.
  always_comb begin
    rsp_addr  = (state_q == S_IDLE) ? PADDR : addr_q;
    rsp_write = (state_q == S_IDLE) ? PWRITE : write_q;
    rsp_idx   = 32'(rsp_addr >> LSB);
    rsp_err   = ((rsp_addr & ALIGN_MASK) != '0) ||
                (rsp_idx >= 32'(DEPTH)) ||
                (rsp_write && ((rsp_idx + 32'd1) <= 32'(RO_WORDS)));
    rsp_data  = '0;
    if (!rsp_err && !rsp_write) rsp_data = mem[rsp_idx[MEM_AW-1:0]];
  end

  assign complete = (state_q == S_ACCESS) && PSEL && PENABLE && pready_q;
  assign mem_we   = complete && write_q && !pslverr_q;
  assign wr_idx   = 32'(PADDR >> LSB);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    errcnt_d  = errcnt_q;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          cnt_d   = WS;
          state_d = S_ACCESS;
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            prdata_d  = rsp_data;
          end
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          // Master abandoned the transfer: drop it without side effects.
          state_d   = S_IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (!pready_q) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            prdata_d  = rsp_data;
          end
        end else if (PENABLE) begin
          state_d   = S_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
          if (pslverr_q && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      errcnt_q  <= errcnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge PCLK) begin
    if (mem_we && (wr_idx < 32'(DEPTH))) begin
      for (int b = 0; b < NB; b++) begin
        if (PSTRB[b]) mem[wr_idx[MEM_AW-1:0]][b*8 +: 8] <= PWDATA[b*8 +: 8];
      end
    end
  end

  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign err_count = errcnt_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (zero-wait small RAM with read-only words,
// three-wait full RAM) driven by a table, corner-case sequences and random traffic.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] paddr;
  logic        psel0, psel1, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic [7:0]  errcnt0, errcnt1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(512), .WAIT_STATES(0), .RO_WORDS(4)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PSEL(psel0), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0),
    .PREADY(pready0), .PSLVERR(pslverr0), .err_count(errcnt0));

  apb_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(3), .RO_WORDS(0)) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PSEL(psel1), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata1),
    .PREADY(pready1), .PSLVERR(pslverr1), .err_count(errcnt1));

  // Reference model: byte-level storage with a known flag per byte.
  logic [7:0] mb [2][1024][4];
  bit         mk [2][1024][4];
  int         ecnt [2];

  typedef struct {
    int          w;
    logic [11:0] a;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  sb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic sel_pready(input int w);
    return (w == 1) ? pready1 : pready0;
  endfunction
  function automatic logic sel_pslverr(input int w);
    return (w == 1) ? pslverr1 : pslverr0;
  endfunction
  function automatic logic [31:0] sel_prdata(input int w);
    return (w == 1) ? prdata1 : prdata0;
  endfunction
  function automatic logic [7:0] sel_errcnt(input int w);
    return (w == 1) ? errcnt1 : errcnt0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic ref_xfer(input int w, input logic [11:0] a, input logic wr, input logic [31:0] wd,
                          input logic [3:0] sb, output logic [31:0] erd, output logic [31:0] emask,
                          output logic eerr);
    int depth = (w == 1) ? 1024 : 512;
    int ro    = (w == 1) ? 0 : 4;
    int idx   = int'(a) / 4;
    eerr  = (a[1:0] != 2'b00) || (idx >= depth) || (wr && (idx < ro));
    erd   = '0;
    emask = '1;
    if (eerr) begin
      if (ecnt[w] < 255) ecnt[w]++;
    end else if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (sb[b]) begin
          mb[w][idx][b] = wd[8*b +: 8];
          mk[w][idx][b] = 1'b1;
        end
      end
    end else begin
      emask = '0;
      for (int b = 0; b < 4; b++) begin
        if (mk[w][idx][b]) begin
          erd[8*b +: 8]   = mb[w][idx][b];
          emask[8*b +: 8] = 8'hFF;
        end
      end
    end
  endtask

  task automatic xfer(input int w, input logic [11:0] a, input logic wr, input logic [31:0] wd,
                      input logic [3:0] sb, output logic [31:0] rd, output logic er,
                      output int waits, output bit ok);
    rd = '0; er = 1'b0; waits = 0; ok = 1'b0;
    @(posedge clk); #1;
    paddr = a; pwrite = wr; pwdata = wd; pstrb = sb; penable = 1'b0;
    if (w == 1) psel1 = 1'b1; else psel0 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel_pready(w)) begin
        rd = sel_prdata(w);
        er = sel_pslverr(w);
        ok = 1'b1;
        break;
      end
      waits++;
    end
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  task automatic run(input int w, input logic [11:0] a, input logic wr, input logic [31:0] wd,
                     input logic [3:0] sb, input string tag, output logic [31:0] rd, output logic er);
    int waits; bit ok;
    logic [31:0] erd, emask; logic eerr;
    xfer(w, a, wr, wd, sb, rd, er, waits, ok);
    ref_xfer(w, a, wr, wd, sb, erd, emask, eerr);
    check({tag, " ready"}, 32'(ok), 32'd1);
    check({tag, " waits"}, 32'(waits), (w == 1) ? 32'd3 : 32'd0);
    check({tag, " pslverr"}, 32'(er), 32'(eerr));
    if (!wr) check({tag, " prdata"}, rd & emask, erd);
    check({tag, " err_count"}, 32'(sel_errcnt(w)), 32'(ecnt[w]));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    rst_n = 1'b0; paddr = '0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; pwdata = '0; pstrb = '0;
    ecnt[0] = 0; ecnt[1] = 0;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 1024; i++)
        for (int b = 0; b < 4; b++) begin
          mk[w][i][b] = 1'b0;
          mb[w][i][b] = 8'h00;
        end

    #12;
    check("rst pready0", 32'(pready0), 32'd0);
    check("rst pslverr0", 32'(pslverr0), 32'd0);
    check("rst prdata0", prdata0, 32'd0);
    check("rst errcnt0", 32'(errcnt0), 32'd0);
    check("rst pready1", 32'(pready1), 32'd0);
    check("rst errcnt1", 32'(errcnt1), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    vecs.push_back('{0, 12'h100, 1'b1, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{0, 12'h100, 1'b0, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0});
    vecs.push_back('{0, 12'h002, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{0, 12'hFFC, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{0, 12'h00C, 1'b1, 32'h00000055, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{0, 12'h010, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{0, 12'h010, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{1, 12'h008, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1, 12'h008, 1'b1, 32'h12345678, 4'h5, 32'h0, 1'b0});
    vecs.push_back('{1, 12'h008, 1'b0, 32'h0, 4'hF, 32'hFF34FF78, 1'b0});
    vecs.push_back('{1, 12'h004, 1'b1, 32'h0BADC0DE, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1, 12'h004, 1'b0, 32'h0, 4'hF, 32'h0BADC0DE, 1'b0});
    vecs.push_back('{1, 12'h004, 1'b1, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1, 12'h004, 1'b0, 32'h0, 4'hF, 32'h0BADC0DE, 1'b0});
    vecs.push_back('{1, 12'h020, 1'b1, 32'h11111111, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1, 12'h7FE, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1});

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run(vecs[i].w, vecs[i].a, vecs[i].wr, vecs[i].wd, vecs[i].sb, tag, rd, er);
      check({tag, " tbl_err"}, 32'(er), 32'(vecs[i].exp_err));
      if (!vecs[i].wr) check({tag, " tbl_data"}, rd, vecs[i].exp_rd);
    end
    check("tbl errcnt0", 32'(errcnt0), 32'd3);
    check("tbl errcnt1", 32'(errcnt1), 32'd1);

    // Abort: drop PSEL in the middle of a waited write to 0x020.
    @(posedge clk); #1;
    paddr = 12'h020; pwrite = 1'b1; pwdata = 32'h22222222; pstrb = 4'hF;
    psel1 = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel1 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("abort pready", 32'(pready1), 32'd0);
    check("abort errcnt", 32'(errcnt1), 32'd1);
    run(1, 12'h020, 1'b0, 32'h0, 4'hF, "post_abort", rd, er);
    check("abort no_write", rd, 32'h11111111);

    for (int i = 0; i < 150; i++) begin
      int          w, idx, r;
      logic [11:0] a;
      logic        wr;
      logic [31:0] wd;
      logic [3:0]  sb;
      w   = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 23));
      a   = 12'(idx * 4);
      r   = int'($urandom_range(0, 9));
      if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
      else if (r == 1 && w == 0) a = a | 12'h800;
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      sb  = 4'($urandom_range(0, 15));
      run(w, a, wr, wd, sb, $sformatf("rnd%0d", i), rd, er);
    end

    // Asynchronous reset while an error response is being presented.
    @(posedge clk); #1;
    paddr = 12'h002; pwrite = 1'b0; psel0 = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    check("pre_rst pready", 32'(pready0), 32'd1);
    check("pre_rst pslverr", 32'(pslverr0), 32'd1);
    check("pre_rst errcnt", 32'(errcnt0), 32'(ecnt[0]));
    penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async pready", 32'(pready0), 32'd0);
    check("async pslverr", 32'(pslverr0), 32'd0);
    check("async prdata", prdata0, 32'd0);
    check("async errcnt0", 32'(errcnt0), 32'd0);
    check("async errcnt1", 32'(errcnt1), 32'd0);
    ecnt[0] = 0; ecnt[1] = 0;
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(0, 12'h100, 1'b0, 32'h0, 4'hF, "mem_kept", rd, er);
    check("mem_kept value", rd, 32'hA5A5A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, want completion");
    $fatal(1, "watchdog");
  end

endmodule
